// File: rtl/count_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_deser_if
//  Description : Symbol-in / count-out bundle for count_deser.
//                master : symbol source (drives sym_valid/sym_sof/sym and
//                         observes the reassembled count and status).
//                slave  : the deserialiser itself.
//  Signals     : sym_valid   symbol present this cycle
//                sym_sof     first symbol of a frame (qualified by sym_valid)
//                sym         received symbol, MSB-symbol first
//                count       last good reassembled word
//                count_valid one-cycle pulse, count updated
//                frame_err   one-cycle pulse on framing / check error
//                busy        frame partially received
//                frames_ok   good words delivered, modulo 256
//  Revision    : 1.0  initial release
// ============================================================================
interface count_deser_if #(
   parameter int WORD_W = 16,
   parameter int SYM_W  = 2
);
   logic              sym_valid;
   logic              sym_sof;
   logic [SYM_W-1:0]  sym;
   logic [WORD_W-1:0] count;
   logic              count_valid;
   logic              frame_err;
   logic              busy;
   logic [7:0]        frames_ok;

   modport master (
      output sym_valid, sym_sof, sym,
      input  count, count_valid, frame_err, busy, frames_ok
   );

   modport slave (
      input  sym_valid, sym_sof, sym,
      output count, count_valid, frame_err, busy, frames_ok
   );
endinterface
`default_nettype wire

// File: rtl/count_deser.sv
`default_nettype none
// ============================================================================
//  Module      : count_deser
//  Description : Reassembles WORD_W-bit count words from SYM_W-bit symbols
//                sent MSB-symbol first. A frame starts with a sym_sof symbol
//                and is NSYM = WORD_W/SYM_W symbols long; gaps (sym_valid=0)
//                of any length are accepted inside a frame. A sof arriving
//                mid-frame aborts the partial word and restarts. Good words
//                appear on count one cycle after their last symbol.
//                Optional feature macro: COUNT_DESER_PARITY_EN -- each frame
//                is followed by a check symbol whose bit 0 is the even
//                parity (XOR) of the word; mismatch raises frame_err.
//  Ports       : clk  rising-edge clock
//                rst  asynchronous active-high reset
//                bus  count_deser_if.slave (symbol input, count/status out)
//  Parameters  : WORD_W word width, SYM_W symbol width (WORD_W multiple of
//                SYM_W, at least two symbols per word)
//  Revision    : 1.0  initial release
// ============================================================================
module count_deser #(
   parameter int WORD_W = 16,
   parameter int SYM_W  = 2
) (
   input  wire logic    clk,
   input  wire logic    rst,
   count_deser_if.slave bus
);
   localparam int NSYM  = WORD_W / SYM_W;
   localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

`ifdef COUNT_DESER_PARITY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_CHECK = 2'd2} state_t;
`else
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;
`endif

   state_t            state_q,  state_d;
   logic [IDX_W-1:0]  idx_q,    idx_d;
   logic [WORD_W-1:0] shreg_q,  shreg_d;
   logic [WORD_W-1:0] count_q,  count_d;
   logic              cvalid_q, cvalid_d;
   logic              ferr_q,   ferr_d;
   logic [7:0]        frames_q, frames_d;

   // Shift register with the incoming symbol dropped into the slot for the
   // current index (slot 0 is the top SYM_W bits).
   logic [WORD_W-1:0] w_word;

   always_comb begin
      w_word = shreg_q;
      for (int i = 0; i < NSYM; i++) begin
         if (idx_q == IDX_W'(i)) begin
            w_word[WORD_W-1-i*SYM_W -: SYM_W] = bus.sym;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      count_d  = count_q;
      cvalid_d = 1'b0;
      ferr_d   = 1'b0;
      frames_d = frames_q;

      if (bus.sym_valid) begin
         if (bus.sym_sof) begin
            // sof always (re)starts a frame; it is an error only if it
            // cuts a partial frame short, including at the check symbol.
            ferr_d  = (state_q != S_IDLE);
            state_d = S_RECV;
            idx_d   = IDX_W'(1);
            shreg_d = {bus.sym, {(WORD_W-SYM_W){1'b0}}};
         end else begin
            case (state_q)
               S_IDLE: begin
                  ferr_d = 1'b1;
               end
               S_RECV: begin
                  if (idx_q == LAST_IDX) begin
`ifdef COUNT_DESER_PARITY_EN
                     shreg_d = w_word;
                     idx_d   = '0;
                     state_d = S_CHECK;
`else
                     count_d  = w_word;
                     cvalid_d = 1'b1;
                     frames_d = frames_q + 8'd1;
                     state_d  = S_IDLE;
                     idx_d    = '0;
                     shreg_d  = '0;
`endif
                  end else begin
                     shreg_d = w_word;
                     idx_d   = idx_q + 1'b1;
                  end
               end
`ifdef COUNT_DESER_PARITY_EN
               S_CHECK: begin
                  if (bus.sym[0] == ^shreg_q) begin
                     count_d  = shreg_q;
                     cvalid_d = 1'b1;
                     frames_d = frames_q + 8'd1;
                  end else begin
                     ferr_d = 1'b1;
                  end
                  state_d = S_IDLE;
                  idx_d   = '0;
                  shreg_d = '0;
               end
`endif
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         shreg_q  <= '0;
         count_q  <= '0;
         cvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         frames_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         count_q  <= count_d;
         cvalid_q <= cvalid_d;
         ferr_q   <= ferr_d;
         frames_q <= frames_d;
      end
   end

   assign bus.count       = count_q;
   assign bus.count_valid = cvalid_q;
   assign bus.frame_err   = ferr_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.frames_ok   = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_count_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_deser
//  Description : Self-checking bench for count_deser. A frame-level model
//                (queue of collected symbols, word built arithmetically)
//                predicts every registered output each cycle; directed
//                sequences add literal expectations. Honours
//                COUNT_DESER_PARITY_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_deser;
   localparam int WORD_W = 16;
   localparam int SYM_W  = 2;
   localparam int NSYM   = WORD_W / SYM_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   count_deser_if #(.WORD_W(WORD_W), .SYM_W(SYM_W)) bus ();
   count_deser    #(.WORD_W(WORD_W), .SYM_W(SYM_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int cv_cnt = 0;
   int fe_cnt = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_in     = 1'b0;  // inside a frame (busy)
   bit          m_chk    = 1'b0;  // all data symbols in, waiting for check
   int          m_syms[$];
   logic [15:0] m_count  = '0;
   bit          m_cv     = 1'b0;
   bit          m_fe     = 1'b0;
   int          m_frames = 0;

   function automatic int fold(int q[$]);
      int w = 0;
      foreach (q[i]) w = w * (1 << SYM_W) + q[i];
      return w;
   endfunction

   function automatic void m_deliver(int w);
      m_count  = w[15:0];
      m_cv     = 1'b1;
      m_frames = (m_frames + 1) % 256;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_in = 0; m_chk = 0; m_syms.delete();
         m_count = '0; m_cv = 0; m_fe = 0; m_frames = 0;
      end else begin
         m_cv = 0;
         m_fe = 0;
         if (bus.sym_valid) begin
            if (bus.sym_sof) begin
               if (m_in) m_fe = 1;
               m_syms.delete();
               m_syms.push_back(int'(bus.sym));
               m_in  = 1;
               m_chk = 0;
            end else if (!m_in) begin
               m_fe = 1;
            end else if (m_chk) begin
               if (bus.sym[0] == ((^fold(m_syms)) & 1'b1)) m_deliver(fold(m_syms));
               else m_fe = 1;
               m_in = 0; m_chk = 0; m_syms.delete();
            end else begin
               m_syms.push_back(int'(bus.sym));
               if (m_syms.size() == NSYM) begin
`ifdef COUNT_DESER_PARITY_EN
                  m_chk = 1;
`else
                  m_deliver(fold(m_syms));
                  m_in = 0; m_syms.delete();
`endif
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("count",       32'(bus.count),       32'(m_count));
      chk("count_valid", 32'(bus.count_valid), 32'(m_cv));
      chk("frame_err",   32'(bus.frame_err),   32'(m_fe));
      chk("busy",        32'(bus.busy),        32'(m_in));
      chk("frames_ok",   32'(bus.frames_ok),   32'(m_frames));
      if (bus.count_valid === 1'b1) cv_cnt++;
      if (bus.frame_err === 1'b1)   fe_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic send_sym(bit sof, logic [1:0] s, int gap);
      @(negedge clk);
      bus.sym_valid = 1'b1; bus.sym_sof = sof; bus.sym = s;
      repeat (gap) begin
         @(negedge clk);
         bus.sym_valid = 1'b0; bus.sym_sof = 1'($urandom); bus.sym = 2'($urandom);
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         bus.sym_valid = 1'b0; bus.sym_sof = 1'b0;
      end
   endtask

   // Full frame; gap idle cycles between symbols (none after the last).
   task automatic send_frame(logic [15:0] w, int gap, bit bad_par);
      logic [1:0] s;
      for (int i = 0; i < NSYM; i++) begin
         s = w[15-2*i -: 2];
`ifdef COUNT_DESER_PARITY_EN
         send_sym(i == 0, s, gap);
`else
         send_sym(i == 0, s, (i == NSYM-1) ? 0 : gap);
`endif
      end
`ifdef COUNT_DESER_PARITY_EN
      s = {1'($urandom), (^w) ^ bad_par};
      send_sym(1'b0, s, 0);
`else
      if (bad_par) s = 2'b00;  // no check symbol in this build
`endif
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1; bus.sym_valid = 1'b0; bus.sym_sof = 1'b0;
      #1;
      chk("rst_count",  32'(bus.count),     32'h0);
      chk("rst_busy",   32'(bus.busy),      32'h0);
      chk("rst_frames", 32'(bus.frames_ok), 32'h0);
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   int cv0, fe0, r, k;
   logic [15:0] w;

   initial begin
      bus.sym_valid = 1'b0; bus.sym_sof = 1'b0; bus.sym = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_count",  32'(bus.count),       32'h0);
      chk("init_cv",     32'(bus.count_valid), 32'h0);
      chk("init_fe",     32'(bus.frame_err),   32'h0);
      chk("init_busy",   32'(bus.busy),        32'h0);
      chk("init_frames", 32'(bus.frames_ok),   32'h0);
      @(posedge clk); #2;
      rst = 1'b0;

      // Contiguous A5C3 frame
      cv0 = cv_cnt;
      send_frame(16'hA5C3, 0, 1'b0);
      idle(1); #1;
      chk("a5c3_count",   32'(bus.count),       32'hA5C3);
      chk("a5c3_pulse",   32'(bus.count_valid), 32'h1);
      chk("a5c3_busy",    32'(bus.busy),        32'h0);
      chk("a5c3_frames",  32'(bus.frames_ok),   32'h1);
      chk("model_a5c3",   32'(m_count),         32'hA5C3);
      idle(2); #1;
      chk("a5c3_npulse",  32'(cv_cnt - cv0),    32'h1);

      // Same frame with 3-cycle gaps
      cv0 = cv_cnt;
      send_frame(16'hA5C3, 3, 1'b0);
      idle(1); #1;
      chk("gap_count",  32'(bus.count),     32'hA5C3);
      chk("gap_frames", 32'(bus.frames_ok), 32'h2);
      idle(1); #1;
      chk("gap_npulse", 32'(cv_cnt - cv0),  32'h1);

      // sof on symbol 5 of an FFFF frame starts a full 1234 frame
      cv0 = cv_cnt; fe0 = fe_cnt;
      for (int i = 0; i < 5; i++) send_sym(i == 0, 2'b11, 0);
      send_frame(16'h1234, 0, 1'b0);
      idle(1); #1;
      chk("abort_count",  32'(bus.count),     32'h1234);
      chk("abort_frames", 32'(bus.frames_ok), 32'h3);
      idle(1); #1;
      chk("abort_nerr",   32'(fe_cnt - fe0),  32'h1);
      chk("abort_npulse", 32'(cv_cnt - cv0),  32'h1);

      // Reset mid-frame, stray symbol, then 0001
      for (int i = 0; i < 4; i++) send_sym(i == 0, 2'b10, 0);
      fe0 = fe_cnt;
      do_reset();
      send_sym(1'b0, 2'b01, 0);
      send_frame(16'h0001, 0, 1'b0);
      idle(1); #1;
      chk("rstmid_count",  32'(bus.count),     32'h0001);
      chk("rstmid_frames", 32'(bus.frames_ok), 32'h1);
      chk("rstmid_nerr",   32'(fe_cnt - fe0),  32'h1);

`ifdef COUNT_DESER_PARITY_EN
      // Good and bad parity
      send_frame(16'hA5C3, 0, 1'b0);
      idle(1); #1;
      chk("par_good_count", 32'(bus.count), 32'hA5C3);
      fe0 = fe_cnt;
      send_frame(16'hA5C3 ^ 16'h0100, 0, 1'b1);
      idle(2); #1;
      chk("par_bad_count", 32'(bus.count),   32'hA5C3);
      chk("par_bad_nerr",  32'(fe_cnt - fe0), 32'h1);
`endif

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         w = 16'($urandom);
         if (r < 65) begin
            send_frame(w, $urandom_range(0, 2), 1'b0);
         end else if (r < 78) begin
            k = $urandom_range(1, NSYM);
            for (int i = 0; i < k; i++) send_sym(i == 0, 2'($urandom), $urandom_range(0, 1));
         end else if (r < 86) begin
            send_sym(1'b0, 2'($urandom), 0);
         end else if (r < 93) begin
            idle($urandom_range(1, 4));
         end else if (r < 98) begin
            send_frame(w, 0, 1'b1);
         end else begin
            do_reset();
         end
      end
      idle(2);

      // 256 back-to-back frames wrap frames_ok
      do_reset();
      cv0 = cv_cnt;
      for (int i = 0; i < 256; i++) send_frame(16'($urandom), 0, 1'b0);
      idle(1); #1;
      chk("wrap_frames", 32'(bus.frames_ok), 32'h0);
      idle(1); #1;
      chk("wrap_npulse", 32'(cv_cnt - cv0),  32'd256);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/count_deser.md
COUNT_DESER -- requirements
Module: count_deser

Interface
REQ-001 Parameter WORD_W, default 16, width of the reassembled count word.
REQ-002 Parameter SYM_W, default 2, width of one received symbol; WORD_W SHALL be an integer multiple of SYM_W; NSYM = WORD_W/SYM_W.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sym_valid  input  1  symbol on sym is present this cycle.
REQ-006 sym_sof  input  1  qualifies sym as first symbol of a frame (ignored when sym_valid=0).
REQ-007 sym  input  SYM_W  received symbol; frames are sent MSB-symbol first.
REQ-008 count  output  WORD_W  last good reassembled word; held until the next good word.
REQ-009 count_valid  output  1  one-cycle pulse, count updated this cycle.
REQ-010 frame_err  output  1  one-cycle pulse on any framing or check error.
REQ-011 busy  output  1  high while a frame is partially received.
REQ-012 frames_ok  output  8  number of good words delivered, modulo 256.

Function
REQ-013 FSM states SHALL be IDLE and RECV, plus CHECK when COUNT_DESER_PARITY_EN is defined.
REQ-014 IDLE: sym_valid & sym_sof -> load sym into the top SYM_W bits of the shift register, set the symbol index to 1, go to RECV.
REQ-015 IDLE: sym_valid & !sym_sof -> discard the symbol, pulse frame_err next cycle, stay in IDLE.
REQ-016 RECV: sym_valid & !sym_sof -> shift sym in below the symbols already received and increment the index.
REQ-017 RECV: sym_valid=0 -> hold all state; gaps of any length SHALL be accepted.
REQ-018 RECV: sym_valid & sym_sof -> drop the partial word, pulse frame_err, restart with this symbol as symbol 0; sof SHALL take precedence even on the would-be last symbol.
REQ-019 Parity off: on acceptance of symbol NSYM-1 -> count, count_valid=1 and frames_ok+1 are registered the next cycle (latency 1 clk after last symbol); state -> IDLE.
REQ-020 A new sof symbol SHALL be accepted in the cycle immediately after the last symbol (back-to-back frames, no dead cycle).
REQ-021 busy = (state != IDLE); it deasserts in the same cycle that count_valid asserts.
REQ-022 frames_ok SHALL wrap 255 -> 0 with no other effect.
REQ-023 count SHALL NOT change on an aborted or erroneous frame.
REQ-024 count_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, index=0, shift register=0, count=0, count_valid=0, frame_err=0, busy=0, frames_ok=0.
REQ-026 Reset mid-frame SHALL discard the partial word silently, with no frame_err pulse; the first symbol after release SHALL require sym_sof.

Configuration
REQ-027 Macro COUNT_DESER_PARITY_EN defined: after symbol NSYM-1 go to CHECK; the next valid symbol carries even parity in bit 0 (XOR of all WORD_W bits); match -> deliver as in REQ-019 one cycle after the check symbol; mismatch -> frame_err pulse, count unchanged; sof on the check symbol -> treated per REQ-018.
REQ-028 Macro undefined: no CHECK state, no parity symbol, frame length exactly NSYM symbols.

Verification
REQ-029 Symbols 10,10,01,01,11,00,00,11 (first with sof), contiguous -> count=16'hA5C3, count_valid one pulse one cycle after the last symbol, frames_ok=1.
REQ-030 Same frame with 3-cycle sym_valid gaps between symbols -> count=16'hA5C3; busy high from symbol 0 until the delivery cycle.
REQ-031 sof re-asserted on symbol 5 of a 0xFFFF frame, followed by a full 0x1234 frame -> one frame_err pulse, then count=16'h1234, frames_ok+1 only once.
REQ-032 rst pulsed after 4 symbols, then a non-sof symbol, then a full 0x0001 frame -> count=0 after reset, one frame_err for the stray symbol, then count=16'h0001.
REQ-033 256 back-to-back good frames -> frames_ok wraps to 0; no idle cycle is required between frames.
REQ-034 With COUNT_DESER_PARITY_EN: 0xA5C3 with check symbol bit0=0 -> delivered; with bit0=1 -> frame_err, count unchanged.
